// File: rtl/led_sched_pkg.sv
// Shared definitions for the LED blink scheduler.
// Contents: scheduler state encoding, the tick counter width, and a ceil-log2
// helper that never returns less than 1 so derived vector widths stay legal.
package led_sched_pkg;

  // Scheduler phases: waiting for a grant, LED lit, dark gap after a pulse
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Width of the tick counter; covers ON/OFF lengths up to 8191 ticks
  localparam int TICK_W = 13;

  // ceil(log2(value)), clamped to a minimum of 1
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/led_blink_scheduler_rr_arbiter.sv
// Round-robin priority search used by the LED blink scheduler.
// Ports:
//   ptr_i     - index of the source with highest priority this cycle
//   pend_i    - pending request vector
//   gnt_idx_o - first pending index found searching upward from ptr_i (with wrap)
//   gnt_vld_o - high when any request is pending
// Purely combinational; the pointer register lives in the parent.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int OW = 2
) (
  input  logic [OW-1:0] ptr_i,
  input  logic [N-1:0]  pend_i,
  output logic [OW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  // Walk the sources starting at the pointer and take the first pending one
  always_comb begin
    gnt_idx_o = {OW{1'b0}};
    gnt_vld_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!gnt_vld_o && pend_i[(int'(ptr_i) + k) % N]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = OW'((int'(ptr_i) + k) % N);
      end else begin
        gnt_vld_o = gnt_vld_o;
      end
    end
  end

endmodule

// File: rtl/led_blink_scheduler.sv
// LED blink scheduler: shares one front-panel LED among N_REQ activity sources.
// Requests are latched as pending, granted round-robin, and each grant lights
// the LED for ON_TICKS ticks followed by an OFF_TICKS dark gap.
// Ports:
//   CK      - system clock, all state on rising edge
//   RST     - asynchronous active-high reset
//   ENABLE  - scheduler enable; low aborts any pulse and blocks new grants
//   REQ     - per-source activity strobe, level-sampled every cycle
//   LED     - registered LED drive
//   BUSY    - high while in ON or GAP
//   OWNER   - source currently or most recently granted
//   PENDING - latched pending requests
module led_blink_scheduler
  import led_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int PRESCALE  = 8,
  parameter int ON_TICKS  = 8191,
  parameter int OFF_TICKS = 1024,
  parameter int OW        = clog2_min1(N_REQ)
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             ENABLE,
  input  logic [N_REQ-1:0] REQ,
  output logic             LED,
  output logic             BUSY,
  output logic [OW-1:0]    OWNER,
  output logic [N_REQ-1:0] PENDING
);

  localparam int                PW         = clog2_min1(PRESCALE);
  localparam logic [PW-1:0]     PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [TICK_W-1:0] ON_LAST    = TICK_W'(ON_TICKS - 1);
  localparam logic [TICK_W-1:0] OFF_LAST   = TICK_W'((OFF_TICKS > 0) ? OFF_TICKS - 1 : 0);
  localparam logic [OW-1:0]     PTR_LAST   = OW'(N_REQ - 1);

  state_e             state_q;
  logic               led_q;
  logic               busy_q;
  logic [OW-1:0]      owner_q;
  logic [OW-1:0]      ptr_q;
  logic [N_REQ-1:0]   pend_q;
  logic [N_REQ-1:0]   pend_d;
  logic [PW-1:0]      presc_q;
  logic [TICK_W-1:0]  ticks_q;

  logic               arb_vld_s;
  logic [OW-1:0]      arb_idx_s;
  logic [OW-1:0]      ptr_nxt_s;
  logic [N_REQ-1:0]   grant_mask_s;
  logic               grant_s;
  logic               tick_s;

  rr_arbiter #(
    .N  (N_REQ),
    .OW (OW)
  ) u_arb (
    .ptr_i     (ptr_q),
    .pend_i    (pend_q),
    .gnt_idx_o (arb_idx_s),
    .gnt_vld_o (arb_vld_s)
  );

  // Grant decision, prescaler tick, and pending-vector update (new requests win over clear)
  always_comb begin
    grant_s   = (state_q == ST_IDLE) && ENABLE && arb_vld_s;
    tick_s    = (presc_q == PRESC_LAST);
    ptr_nxt_s = (arb_idx_s == PTR_LAST) ? {OW{1'b0}} : arb_idx_s + OW'(1);
    if (grant_s) begin
      grant_mask_s = {{(N_REQ-1){1'b0}}, 1'b1} << arb_idx_s;
    end else begin
      grant_mask_s = {N_REQ{1'b0}};
    end
    pend_d = (pend_q & ~grant_mask_s) | REQ;
  end

  // Scheduler FSM with registered LED/BUSY/OWNER and the ON/GAP timers
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      owner_q <= {OW{1'b0}};
      ptr_q   <= {OW{1'b0}};
      pend_q  <= {N_REQ{1'b0}};
      presc_q <= {PW{1'b0}};
      ticks_q <= {TICK_W{1'b0}};
    end else begin
      pend_q <= pend_d;
      case (state_q)
        ST_IDLE: begin
          if (grant_s) begin
            state_q <= ST_ON;
            led_q   <= 1'b1;
            busy_q  <= 1'b1;
            owner_q <= arb_idx_s;
            ptr_q   <= ptr_nxt_s;
            presc_q <= {PW{1'b0}};
            ticks_q <= {TICK_W{1'b0}};
          end
        end
        ST_ON, ST_GAP: begin
          if (!ENABLE) begin
            // Abort: go dark at once; PENDING and OWNER are left untouched
            state_q <= ST_IDLE;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            presc_q <= {PW{1'b0}};
            ticks_q <= {TICK_W{1'b0}};
          end else if (tick_s) begin
            presc_q <= {PW{1'b0}};
            if (state_q == ST_ON && ticks_q == ON_LAST) begin
              led_q   <= 1'b0;
              ticks_q <= {TICK_W{1'b0}};
              if (OFF_TICKS > 0) begin
                state_q <= ST_GAP;
              end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end else if (state_q == ST_GAP && ticks_q == OFF_LAST) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              ticks_q <= {TICK_W{1'b0}};
            end else begin
              ticks_q <= ticks_q + TICK_W'(1);
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          led_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign LED     = led_q;
  assign BUSY    = busy_q;
  assign OWNER   = owner_q;
  assign PENDING = pend_q;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Testbench for led_blink_scheduler. Three instances share the same stimulus:
//   a: PRESCALE=2 ON=3 OFF=2   b: PRESCALE=2 ON=3 OFF=0   c: PRESCALE=1 ON=4 OFF=1
// A timeline reference model (grant time plus elapsed cycles) predicts every
// output; predictions are queued and a separate monitor compares them.
module tb_led_blink_scheduler;

  localparam int NI = 3;

  logic       ck = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] req = 4'b0000;

  logic       led_w   [NI];
  logic       busy_w  [NI];
  logic [1:0] owner_w [NI];
  logic [3:0] pend_w  [NI];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state
  bit         m_act   [NI];
  int         m_start [NI];
  int         m_owner [NI];
  int         m_ptr   [NI];
  logic [3:0] m_pend  [NI];

  typedef struct {
    int k;
    int led;
    int busy;
    int owner;
    int pend;
  } snap_t;

  typedef struct {
    int k;
    int owner;
    int cyc;
  } gnt_t;

  snap_t snap_q[$];
  gnt_t  gq[$];

  always #5 ck = ~ck;

  led_blink_scheduler #(.N_REQ(4), .PRESCALE(2), .ON_TICKS(3), .OFF_TICKS(2)) u_dut_a (
    .CK(ck), .RST(rst), .ENABLE(enable), .REQ(req),
    .LED(led_w[0]), .BUSY(busy_w[0]), .OWNER(owner_w[0]), .PENDING(pend_w[0])
  );

  led_blink_scheduler #(.N_REQ(4), .PRESCALE(2), .ON_TICKS(3), .OFF_TICKS(0)) u_dut_b (
    .CK(ck), .RST(rst), .ENABLE(enable), .REQ(req),
    .LED(led_w[1]), .BUSY(busy_w[1]), .OWNER(owner_w[1]), .PENDING(pend_w[1])
  );

  led_blink_scheduler #(.N_REQ(4), .PRESCALE(1), .ON_TICKS(4), .OFF_TICKS(1)) u_dut_c (
    .CK(ck), .RST(rst), .ENABLE(enable), .REQ(req),
    .LED(led_w[2]), .BUSY(busy_w[2]), .OWNER(owner_w[2]), .PENDING(pend_w[2])
  );

  function automatic int p_of(input int k);
    return (k == 2) ? 1 : 2;
  endfunction

  function automatic int on_of(input int k);
    return (k == 2) ? 4 : 3;
  endfunction

  function automatic int off_of(input int k);
    case (k)
      0:       return 2;
      1:       return 0;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_act[k]   = 1'b0;
      m_start[k] = 0;
      m_owner[k] = 0;
      m_ptr[k]   = 0;
      m_pend[k]  = 4'b0000;
    end
  endtask

  // One clock edge of the reference: a grant opens a window of (ON+OFF)*PRESCALE
  // cycles, the LED is lit for the first ON*PRESCALE of them, ENABLE low closes it.
  task automatic model_edge(input logic [3:0] r, input logic en);
    for (int k = 0; k < NI; k++) begin
      int    gi;
      snap_t s;
      gnt_t  g;
      if (m_act[k]) begin
        if (!en || (cyc - m_start[k]) == (on_of(k) + off_of(k)) * p_of(k)) begin
          m_act[k] = 1'b0;
        end
      end else if (en && m_pend[k] != 4'b0000) begin
        gi = -1;
        for (int j = 0; j < 4; j++) begin
          if (gi < 0 && m_pend[k][(m_ptr[k] + j) % 4]) gi = (m_ptr[k] + j) % 4;
        end
        m_act[k]      = 1'b1;
        m_start[k]    = cyc;
        m_owner[k]    = gi;
        m_ptr[k]      = (gi + 1) % 4;
        m_pend[k][gi] = 1'b0;
        g.k = k;
        g.owner = gi;
        g.cyc = cyc;
        gq.push_back(g);
      end
      m_pend[k] = m_pend[k] | r;
      s.k     = k;
      s.led   = (m_act[k] && (cyc - m_start[k]) < on_of(k) * p_of(k)) ? 1 : 0;
      s.busy  = m_act[k] ? 1 : 0;
      s.owner = m_owner[k];
      s.pend  = int'(m_pend[k]);
      snap_q.push_back(s);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic en);
    req    = r;
    enable = en;
    @(posedge ck);
    cyc++;
    model_edge(r, en);
    #1;
  endtask

  // Monitor: compares queued predictions and checks each LED rising edge
  // against the expected grant (owner and edge number).
  initial begin : monitor
    snap_t s;
    bit    led_prev [NI];
    int    found;
    for (int k = 0; k < NI; k++) led_prev[k] = 1'b0;
    forever begin
      @(negedge ck);
      while (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        chk($sformatf("i%0d c%0d led", s.k, cyc), int'(led_w[s.k]), s.led);
        chk($sformatf("i%0d c%0d busy", s.k, cyc), int'(busy_w[s.k]), s.busy);
        chk($sformatf("i%0d c%0d owner", s.k, cyc), int'(owner_w[s.k]), s.owner);
        chk($sformatf("i%0d c%0d pending", s.k, cyc), int'(pend_w[s.k]), s.pend);
      end
      for (int k = 0; k < NI; k++) begin
        if (led_w[k] && !led_prev[k]) begin
          found = -1;
          for (int i = 0; i < gq.size(); i++) begin
            if (found < 0 && gq[i].k == k) found = i;
          end
          if (found < 0) begin
            chk($sformatf("i%0d c%0d unexpected grant", k, cyc), 1, 0);
          end else begin
            chk($sformatf("i%0d grant owner", k), int'(owner_w[k]), gq[found].owner);
            chk($sformatf("i%0d grant edge", k), cyc, gq[found].cyc);
            gq.delete(found);
          end
        end
        led_prev[k] = led_w[k];
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : driver
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge ck);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("i%0d reset led", k), int'(led_w[k]), 0);
      chk($sformatf("i%0d reset busy", k), int'(busy_w[k]), 0);
      chk($sformatf("i%0d reset owner", k), int'(owner_w[k]), 0);
      chk($sformatf("i%0d reset pending", k), int'(pend_w[k]), 0);
    end
    @(negedge ck);
    #1;
    rst = 1'b0;

    // Single request: pending one edge later, LED one edge after that
    repeat (8) step(4'b0000, 1'b1);
    step(4'b0001, 1'b1);
    chk("s1 pending latched", int'(pend_w[0]), 1);
    chk("s1 led before grant", int'(led_w[0]), 0);
    step(4'b0000, 1'b1);
    chk("s1 led at grant", int'(led_w[0]), 1);
    chk("s1 owner at grant", int'(owner_w[0]), 0);
    chk("s1 pending cleared", int'(pend_w[0]), 0);
    repeat (5) step(4'b0000, 1'b1);
    chk("s1 led after 5 cycles", int'(led_w[0]), 1);
    step(4'b0000, 1'b1);
    chk("s1 led after 6 cycles", int'(led_w[0]), 0);
    chk("s1 busy in gap", int'(busy_w[0]), 1);
    repeat (4) step(4'b0000, 1'b1);
    chk("s1 busy after gap", int'(busy_w[0]), 0);
    repeat (4) step(4'b0000, 1'b1);

    // Three sources at once: grants 0,1,3
    step(4'b1011, 1'b1);
    repeat (40) step(4'b0000, 1'b1);

    // All sources held: round-robin fairness
    repeat (60) step(4'b1111, 1'b1);
    repeat (50) step(4'b0000, 1'b1);

    // ENABLE dropped during ON, with source 2 requesting on the same edge
    step(4'b0001, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0100, 1'b0);
    chk("s4 led after abort", int'(led_w[0]), 0);
    chk("s4 busy after abort", int'(busy_w[0]), 0);
    repeat (3) step(4'b0000, 1'b0);
    chk("s4 pending kept", int'(pend_w[0]), 4);
    chk("s4 owner held", int'(owner_w[0]), 0);
    step(4'b0000, 1'b1);
    chk("s4 regrant led", int'(led_w[0]), 1);
    chk("s4 regrant owner", int'(owner_w[0]), 2);
    repeat (14) step(4'b0000, 1'b1);

    // Reset in the middle of an ON pulse
    step(4'b0010, 1'b1);
    step(4'b1000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    @(negedge ck);
    #1;
    rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("i%0d midrst led", k), int'(led_w[k]), 0);
      chk($sformatf("i%0d midrst busy", k), int'(busy_w[k]), 0);
      chk($sformatf("i%0d midrst owner", k), int'(owner_w[k]), 0);
      chk($sformatf("i%0d midrst pending", k), int'(pend_w[k]), 0);
    end
    repeat (2) @(posedge ck);
    @(negedge ck);
    #1;
    rst = 1'b0;
    model_reset();
    step(4'b0101, 1'b1);
    step(4'b0000, 1'b1);
    chk("s5 first grant after reset", int'(owner_w[0]), 0);
    chk("s5 led after reset grant", int'(led_w[0]), 1);
    repeat (14) step(4'b0000, 1'b1);

    // Random traffic with occasional ENABLE drops
    for (int n = 0; n < 500; n++) begin
      logic [3:0] r;
      logic       en;
      for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 7) == 0);
      en = ($urandom_range(0, 19) != 0);
      step(r, en);
    end
    repeat (60) step(4'b0000, 1'b1);

    @(negedge ck);
    #1;
    chk("leftover expected grants", gq.size(), 0);
    chk("leftover snapshots", snap_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_blink_scheduler.md
Name: led_blink_scheduler

Overview:
- Shares one front-panel LED among N_REQ activity sources, replacing the free-running ripple pulse-stretcher with a synchronous, fully clocked scheduler.
- Each request is latched as pending. A round-robin arbiter grants one source at a time. The LED is lit for a fixed stretched interval, followed by a dark gap, so that bursts from different sources stay visually distinct.
- Sits between the readout/config logic (REQ sources) and the LED pins.

Parameters:
- N_REQ, 4, number of requesting sources (2..16)
- PRESCALE, 8, CK cycles per tick (>=1)
- ON_TICKS, 8191, LED-on length in ticks (1..8191, 13-bit)
- OFF_TICKS, 1024, dark gap in ticks after each ON (0..8191; 0 = no gap)
- OW, clog2(N_REQ), derived OWNER width (min 1)

Ports:
- CK  in  1  system clock, all state on rising edge
- RST  in  1  asynchronous active-high reset
- ENABLE  in  1  scheduler enable; low forces LED dark
- REQ  in  N_REQ  per-source activity strobe, synchronous to CK, level-sampled each cycle
- LED  out  1  LED drive, registered
- BUSY  out  1  high in ON or GAP state
- OWNER  out  OW  index of the source currently or last granted
- PENDING  out  N_REQ  latched pending requests

Behaviour:
- Reset (async, RST=1): state=IDLE; LED=0, BUSY=0, OWNER=0, PENDING=0, prescaler=0, tick counter=0, round-robin pointer=0 (source 0 has highest priority first).
- Pending: REQ[i]=1 at edge t sets PENDING[i] at t+1, independent of ENABLE and state.
  - PENDING[i] clears on the edge that grants i.
  - If REQ[i]=1 on that same edge, PENDING[i] stays set (set wins).
- States: IDLE, ON, GAP (2-bit encoding).
- IDLE:
  - If ENABLE=1 and PENDING!=0: grant the first set bit searching upward from pointer, with wrap.
  - On that edge: state=ON, LED=1, BUSY=1, OWNER=granted, pointer=granted+1 mod N_REQ, prescaler=0, ticks=0.
- Latency: REQ at edge t leads to PENDING at t+1, grant/LED=1 at t+2 (from IDLE with ENABLE=1).
- Prescaler: counts 0..PRESCALE-1 and emits a tick on the PRESCALE-1 wrap. It runs only in ON/GAP.
- ON:
  - On the tick that brings ticks to ON_TICKS: LED=0, ticks=0, prescaler=0.
  - Next state is GAP if OFF_TICKS>0, otherwise IDLE.
  - LED high for exactly ON_TICKS*PRESCALE cycles.
- GAP: after OFF_TICKS ticks (exactly OFF_TICKS*PRESCALE cycles), state=IDLE, BUSY=0.
- IDLE with pending: a new grant may occur on the very next edge. Back-to-back sources therefore have one IDLE cycle between GAP end and the next ON.
- Owner retrigger: REQ[OWNER] during ON/GAP sets pending. It is served by round-robin order and does not extend the current ON.
- ENABLE deassert in ON/GAP:
  - Next edge: state=IDLE, LED=0, BUSY=0, counters cleared.
  - The aborted owner is not re-pended. PENDING is kept, and OWNER holds its value.
- ENABLE=0 in IDLE: no grants. PENDING continues to accumulate.
- Counter widths: ticks counter is 13 bits and never wraps (ends at ON_TICKS/OFF_TICKS). Prescaler width is clog2(PRESCALE), minimum 1.
- PRESCALE=1: tick every cycle.
- Reset mid-operation: immediate return to reset values, with no glitch pulse on LED.

Decomposition:
- Shared package led_sched_pkg holds:
  - state enum (IDLE/ON/GAP)
  - clog2 constant function
  - 13-bit tick width constant
- One natural sub-module, rr_arbiter:
  - Combinational priority search from pointer over PENDING.
  - Returns grant index and a valid flag.
  - Pointer register stays in the parent.

Test Plan (N_REQ=4, PRESCALE=2, ON_TICKS=3, OFF_TICKS=2 unless noted):
- Reset, then a single-cycle REQ=0001 at edge 10 -> PENDING=0001 at 11; LED=1, OWNER=0, PENDING=0 at 12; LED high 6 cycles; BUSY low at edge 22 (6 ON + 4 GAP cycles).
- REQ=1011 in one cycle -> grants in order 0,1,3; each LED pulse is 6 cycles; gaps are 4+1 cycles; PENDING bits clear at their grant edges.
- Fairness: keep REQ=1111 held continuously -> OWNER sequence 0,1,2,3,0,... with no source skipped.
- OFF_TICKS=0, REQ=0011 -> LED high 6 cycles, low 1 cycle (IDLE), high 6 cycles; GAP never entered.
- ENABLE dropped on cycle 3 of ON -> LED=0, BUSY=0 on next edge; PENDING preserved. Raising ENABLE again with PENDING=0100 -> grant 2 after one IDLE cycle.
- RST asserted mid-ON -> LED, BUSY, PENDING, OWNER all 0 asynchronously. After release, REQ[2] and REQ[0] in the same cycle -> grant 0 first (pointer reset to 0).
